alu_baseline: RTL and testbench
===============================

Name: alu_baseline

Overview:
- Single-stage registered integer ALU: ten operations on two WIDTH-bit unsigned operands, selected by a 4-bit opcode.
- Produces a registered result, zero flag, signed-overflow flag and valid strobe one clock after the input is accepted.
- Baseline reference ALU in the SoC datapath; optimised variants keep this exact interface and timing.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; also the shift amount.
- op  input  4  opcode.
- valid_in  input  1  input qualifier.
- result  output  WIDTH  registered result.
- zero  output  1  registered; 1 when the registered result is all zeros.
- overflow  output  1  registered signed-overflow flag.
- valid_out  output  1  registered copy of valid_in.

Behaviour:
- Opcodes, shared package values:
  - ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SHL=0101
  - SHR=0110, LT=0111, EQ=1000, PASS=1001
- ADD: (a+b) mod 2^WIDTH. Overflow = two's-complement overflow (operands same sign, result sign differs). Example: FF+01 -> 00, overflow 0.
- SUB: (a-b) mod 2^WIDTH. Overflow = signed overflow (operand signs differ, result sign differs from a).
- AND/OR/XOR: bitwise.
- SHL/SHR: logical shift of a by unsigned value of full b, zero fill. b >= WIDTH gives 0.
- LT: unsigned a<b gives 1, else 0 (zero-extended to WIDTH).
- EQ: a==b gives 1, else 0.
- PASS: result = a.
- Opcodes 1010-1111: result 0, overflow 0.
- Overflow is 0 for every operation other than ADD/SUB.
- zero = (next result == 0). It is computed combinationally and registered together with result.
- Latency is 1 cycle. Inputs sampled at rising edge N appear on the outputs immediately after edge N.
- valid_out <= valid_in on every edge.
- result, zero and overflow update only on edges where valid_in=1; otherwise they hold their previous value.
- No backpressure. A new operation can be accepted every cycle.
- Reset (asynchronous assert, takes effect immediately): result=0, zero=0, overflow=0, valid_out=0.
- Reset asserted mid-stream discards the in-flight operation. First valid result appears one edge after the first accepted input following deassertion.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 1010 = MUL. Result is the low WIDTH bits of the unsigned a*b. Overflow = 1 if the upper WIDTH bits of the full 2*WIDTH product are non-zero. Latency unchanged (1 cycle).
- Undefined: 1010 behaves as an unused opcode (result 0, overflow 0).

Decomposition:
- Package alu_pkg holds the opcode localparams (including OP_MUL) and the shift-saturation helper constant.
- One natural sub-module, alu_core: purely combinational (a, b, op -> result, zero, overflow).
- alu_baseline wraps alu_core with the output/valid registers and reset.

Test Plan:
- ADD, WIDTH=8:
  - 05+03 -> result 08, zero 0
  - 00+00 -> result 00, zero 1
  - FF+01 -> result 00, zero 1, overflow 0
  - 7F+01 -> result 80, overflow 1
- SUB:
  - 10-05 -> 0B
  - 05-05 -> 00, zero 1
  - 80-01 -> 7F, overflow 1
- Logic:
  - AND F0,0F -> 00, zero 1
  - AND FF,AA -> AA
  - OR F0,0F -> FF
  - XOR AA,55 -> FF
  - XOR FF,FF -> 00, zero 1
- Shift/compare/pass:
  - SHL 01 by 3 -> 08
  - SHR 80 by 2 -> 20
  - SHL 01 by 09 -> 00
  - LT 05,10 -> 01
  - LT 10,05 -> 00, zero 1
  - EQ 42,42 -> 01
  - EQ 42,43 -> 00
  - PASS DE,AD -> DE
- Timing/handshake:
  - Inputs applied before edge N -> outputs updated after edge N.
  - valid_in=0 for 3 cycles -> outputs hold, valid_out=0.
  - Async rst pulse between edges -> all outputs 0 immediately.
- With ALU_MUL_EN, opcode 1010:
  - 0F*11 -> FF, overflow 0
  - 10*10 -> 00, overflow 1, zero 1
- Without ALU_MUL_EN, opcode 1010 -> result 00.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and shift helper for the baseline ALU and its variants.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SHL  = 4'b0101;
  localparam logic [3:0] OP_SHR  = 4'b0110;
  localparam logic [3:0] OP_LT   = 4'b0111;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_PASS = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  // Shift amounts are compared in this many bits; operands wider than this are not supported.
  localparam int unsigned SHIFT_AMT_BITS = 64;

  function automatic logic shift_saturates(input logic [SHIFT_AMT_BITS-1:0] amt,
                                           input int unsigned width);
    return amt >= SHIFT_AMT_BITS'(width);
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: a, b, op -> result, zero, overflow.
// Opcode 1010 is MUL when ALU_MUL_EN is defined, otherwise an unused opcode.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  logic shift_sat;
  assign shift_sat = shift_saturates(SHIFT_AMT_BITS'(b), WIDTH);

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
`endif

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        result   = a + b;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result   = a - b;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL:  result = shift_sat ? '0 : (a << b);
      OP_SHR:  result = shift_sat ? '0 : (a >> b);
      OP_LT:   result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_EQ:   result = {{(WIDTH-1){1'b0}}, (a == b)};
      OP_PASS: result = a;
`ifdef ALU_MUL_EN
      OP_MUL: begin
        result   = prod[WIDTH-1:0];
        overflow = |prod[2*WIDTH-1:WIDTH];
      end
`endif
      default: begin
        result   = '0;
        overflow = 1'b0;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_baseline.sv
// Registered single-stage ALU wrapping alu_core; MUL on opcode 1010 is enabled by ALU_MUL_EN.
module alu_baseline
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  input  logic             valid_in,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             valid_out
);

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_overflow;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a        (a),
    .b        (b),
    .op       (op),
    .result   (core_result),
    .zero     (core_zero),
    .overflow (core_overflow)
  );

  // Handshake: an operation is accepted on every rising edge where valid_in=1 (no
  // backpressure); its outputs appear after that edge with valid_out=1. On edges with
  // valid_in=0 the data outputs hold and valid_out drops to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        result   <= core_result;
        zero     <= core_zero;
        overflow <= core_overflow;
      end
    end
  end

endmodule

// File: tb/tb_alu_baseline.sv
// Self-checking bench for alu_baseline: directed vectors, hold/reset timing, random vs. model.
module tb_alu_baseline;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int MOD  = 1 << W;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic [3:0]   op;
  logic         valid_in;
  logic [W-1:0] result;
  logic         zero, overflow, valid_out;

  int tests = 0;
  int fails = 0;

  // Expected output word: {valid_out, zero, overflow, result}
  logic [W+2:0] exp_q[$];

  // Model of the held output registers
  int held_r = 0;
  bit held_v = 0;
  bit held_z = 0;

  alu_baseline #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .op        (op),
    .valid_in  (valid_in),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .valid_out (valid_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference ALU from the arithmetic rules, using signed/unsigned integers.
  function automatic void ref_alu(input int o, input int ua, input int ub,
                                  output int r, output bit v);
    int sa, sb, t;
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    r = 0;
    v = 0;
    case (o)
      0: begin t = sa + sb; r = (ua + ub) % MOD; v = (t >= HALF) || (t < -HALF); end
      1: begin t = sa - sb; r = (ua - ub + MOD) % MOD; v = (t >= HALF) || (t < -HALF); end
      2: r = ua & ub;
      3: r = ua | ub;
      4: r = ua ^ ub;
      5: r = (ub >= W) ? 0 : (ua * (1 << ub)) % MOD;
      6: r = (ub >= W) ? 0 : ua / (1 << ub);
      7: r = (ua < ub) ? 1 : 0;
      8: r = (ua == ub) ? 1 : 0;
      9: r = ua;
`ifdef ALU_MUL_EN
      10: begin r = (ua * ub) % MOD; v = (ua * ub) >= MOD; end
`endif
      default: begin r = 0; v = 0; end
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                       input logic [W-1:0] y, input logic vin);
    int r;
    bit v;
    logic [W+2:0] e;
    @(negedge clk);
    op = o; a = x; b = y; valid_in = vin;
    if (vin) begin
      ref_alu(int'(o), int'(x), int'(y), r, v);
      held_r = r;
      held_v = v;
      held_z = (r == 0);
    end
    exp_q.push_back({vin, held_z, held_v, W'(held_r)});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check($sformatf("%s valid_out", tag), 32'(valid_out), 32'(e[W+2]));
    check($sformatf("%s zero", tag), 32'(zero), 32'(e[W+1]));
    check($sformatf("%s overflow", tag), 32'(overflow), 32'(e[W]));
    check($sformatf("%s result", tag), 32'(result), 32'(e[W-1:0]));
  endtask

  // Directed vector with hand-derived expectations, also cross-checked against the model.
  task automatic dir(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] er, input logic ev);
    apply(tag, o, x, y, 1'b1);
    check($sformatf("%s exp_result", tag), 32'(result), 32'(er));
    check($sformatf("%s exp_overflow", tag), 32'(overflow), 32'(ev));
    check($sformatf("%s exp_zero", tag), 32'(zero), 32'(er == '0));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; a = '0; b = '0; op = '0; valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset result", 32'(result), 32'h0);
    check("reset zero", 32'(zero), 32'h0);
    check("reset overflow", 32'(overflow), 32'h0);
    check("reset valid_out", 32'(valid_out), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    dir("add 05+03", OP_ADD, 8'h05, 8'h03, 8'h08, 1'b0);
    dir("add 00+00", OP_ADD, 8'h00, 8'h00, 8'h00, 1'b0);
    dir("add FF+01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1'b0);
    dir("add 7F+01", OP_ADD, 8'h7F, 8'h01, 8'h80, 1'b1);
    dir("sub 10-05", OP_SUB, 8'h10, 8'h05, 8'h0B, 1'b0);
    dir("sub 05-05", OP_SUB, 8'h05, 8'h05, 8'h00, 1'b0);
    dir("sub 80-01", OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1);
    dir("and F0,0F", OP_AND, 8'hF0, 8'h0F, 8'h00, 1'b0);
    dir("and FF,AA", OP_AND, 8'hFF, 8'hAA, 8'hAA, 1'b0);
    dir("or F0,0F", OP_OR, 8'hF0, 8'h0F, 8'hFF, 1'b0);
    dir("xor AA,55", OP_XOR, 8'hAA, 8'h55, 8'hFF, 1'b0);
    dir("xor FF,FF", OP_XOR, 8'hFF, 8'hFF, 8'h00, 1'b0);
    dir("shl 01<<3", OP_SHL, 8'h01, 8'h03, 8'h08, 1'b0);
    dir("shr 80>>2", OP_SHR, 8'h80, 8'h02, 8'h20, 1'b0);
    dir("shl 01<<9", OP_SHL, 8'h01, 8'h09, 8'h00, 1'b0);
    dir("shr FF>>8", OP_SHR, 8'hFF, 8'h08, 8'h00, 1'b0);
    dir("shl 81<<7", OP_SHL, 8'h81, 8'h07, 8'h80, 1'b0);
    dir("lt 05,10", OP_LT, 8'h05, 8'h10, 8'h01, 1'b0);
    dir("lt 10,05", OP_LT, 8'h10, 8'h05, 8'h00, 1'b0);
    dir("eq 42,42", OP_EQ, 8'h42, 8'h42, 8'h01, 1'b0);
    dir("eq 42,43", OP_EQ, 8'h42, 8'h43, 8'h00, 1'b0);
    dir("pass DE,AD", OP_PASS, 8'hDE, 8'hAD, 8'hDE, 1'b0);
`ifdef ALU_MUL_EN
    dir("mul 0F*11", OP_MUL, 8'h0F, 8'h11, 8'hFF, 1'b0);
    dir("mul 10*10", OP_MUL, 8'h10, 8'h10, 8'h00, 1'b1);
`else
    dir("op1010 off", OP_MUL, 8'h0F, 8'h11, 8'h00, 1'b0);
`endif
    for (int o = 11; o < 16; o++) begin
      dir($sformatf("unused op %0d", o), 4'(o), 8'hC3, 8'h5A, 8'h00, 1'b0);
    end

    // Idle cycles: outputs hold the last accepted operation.
    dir("pre-hold add", OP_ADD, 8'h05, 8'h03, 8'h08, 1'b0);
    for (int i = 0; i < 3; i++) begin
      apply($sformatf("idle %0d", i), 4'($urandom_range(0, 15)), 8'($urandom),
            8'($urandom), 1'b0);
      check($sformatf("idle %0d held result", i), 32'(result), 32'h08);
    end

    // Reset pulse between edges clears outputs without waiting for a clock.
    dir("pre-reset pass", OP_PASS, 8'hDE, 8'h00, 8'hDE, 1'b0);
    @(negedge clk);
    op = OP_PASS; a = 8'h77; b = 8'h00; valid_in = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("async rst result", 32'(result), 32'h0);
    check("async rst zero", 32'(zero), 32'h0);
    check("async rst overflow", 32'(overflow), 32'h0);
    check("async rst valid_out", 32'(valid_out), 32'h0);
    @(posedge clk);
    #1;
    check("rst held result", 32'(result), 32'h0);
    check("rst held valid_out", 32'(valid_out), 32'h0);
    @(negedge clk);
    valid_in = 1'b0;
    rst = 1'b0;
    held_r = 0; held_v = 0; held_z = 0;
    apply("post-reset idle", OP_ADD, 8'h01, 8'h01, 1'b0);
    dir("post-reset add", OP_ADD, 8'h20, 8'h22, 8'h42, 1'b0);

    // Randomized stream with back-to-back and bubbled operations.
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] x, y;
      logic [3:0]   o;
      x = 8'($urandom);
      y = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      if ($urandom_range(0, 7) == 0) y = x;
      o = 4'($urandom_range(0, 15));
      apply($sformatf("rand %0d op %0d", i, o), o, x, y, ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
